// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Optional IFETCH_PERF_EN adds fetch_count and bubble_count performance counters.
module ifetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               halt_req,
   input  logic               resume,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        istr,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_pc4,
   output logic               if_valid,
   output logic               halted,
   output logic [31:0]        pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [15:0]        bubble_count
`endif
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] istr_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_pc4_q;
   logic        if_valid_q;
   logic        halted_q;
   logic [31:0] pc_plus4;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q[IMEM_AW+1:2];
   assign pc        = pc_q;
   assign istr      = istr_q;
   assign if_pc     = if_pc_q;
   assign if_pc4    = if_pc4_q;
   assign if_valid  = if_valid_q;
   assign halted    = halted_q;

`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_count_q;
   logic [15:0] bubble_count_q;
   logic [15:0] bubble_count_inc;

   // Bubble counter saturates so long stretches of flushing stay visible.
   assign bubble_count_inc = (bubble_count_q == 16'hFFFF) ? bubble_count_q : bubble_count_q + 16'd1;
   assign fetch_count      = fetch_count_q;
   assign bubble_count     = bubble_count_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= PC_RESET;
         istr_q     <= 32'h0;
         if_pc_q    <= 32'h0;
         if_pc4_q   <= 32'h0;
         if_valid_q <= 1'b0;
         halted_q   <= 1'b0;
`ifdef IFETCH_PERF_EN
         fetch_count_q  <= 32'h0;
         bubble_count_q <= 16'h0;
`endif
      end else begin
         case (state_q)
            ST_RUN: begin
               if (redirect_valid) begin
                  pc_q       <= redirect_pc & ~32'h3;
                  istr_q     <= 32'h0;
                  if_valid_q <= 1'b0;
`ifdef IFETCH_PERF_EN
                  bubble_count_q <= bubble_count_inc;
`endif
               end else if (halt_req) begin
                  state_q    <= ST_HALT;
                  halted_q   <= 1'b1;
                  istr_q     <= 32'h0;
                  if_valid_q <= 1'b0;
`ifdef IFETCH_PERF_EN
                  bubble_count_q <= bubble_count_inc;
`endif
               end else if (flush && !stall) begin
                  pc_q       <= pc_plus4;
                  istr_q     <= 32'h0;
                  if_valid_q <= 1'b0;
`ifdef IFETCH_PERF_EN
                  bubble_count_q <= bubble_count_inc;
`endif
               end else if (!stall) begin
                  istr_q     <= imem_data;
                  if_pc_q    <= pc_q;
                  if_pc4_q   <= pc_plus4;
                  if_valid_q <= 1'b1;
                  pc_q       <= pc_plus4;
`ifdef IFETCH_PERF_EN
                  fetch_count_q <= fetch_count_q + 32'd1;
`endif
               end
            end
            ST_HALT: begin
               // Only resume is honoured here; the register keeps emitting bubbles.
               istr_q     <= 32'h0;
               if_valid_q <= 1'b0;
               if (resume) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Table-driven bench for ifetch_stage with a scoreboard queue of packed expected outputs.
// A second instance with PC_RESET=FFFF_FFFC shares the controls to check PC wrap.
module tb_ifetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, redirect_valid, halt_req, resume;
   logic [31:0] redirect_pc;
   logic [9:0]  imem_addr, imem_addr_w;
   logic [31:0] imem_data, imem_data_w;
   logic [31:0] istr, if_pc, if_pc4, pc;
   logic [31:0] istr_w, if_pc_w, if_pc4_w, pc_w;
   logic        if_valid, halted, if_valid_w, halted_w;
`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_count, fetch_count_w;
   logic [15:0] bubble_count, bubble_count_w;
`endif

   logic [31:0] rom [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   // Packed expectation: {pc, istr, if_pc, if_pc4, if_valid, halted}
   logic [129:0] exp_q[$];

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic        hreq;
      logic        res;
      logic [31:0] e_pc;
      logic signed [31:0] e_sel;
      logic [31:0] e_ifpc;
      logic [31:0] e_ifpc4;
      logic        e_v;
      logic        e_h;
   } vec_t;

   vec_t vecs [24];

   always #5 clk = ~clk;

   assign imem_data   = rom[imem_addr];
   assign imem_data_w = rom[imem_addr_w];

   ifetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_AW(10)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .resume(resume),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .istr(istr), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
      .halted(halted), .pc(pc)
`ifdef IFETCH_PERF_EN
      , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
   );

   ifetch_stage #(.PC_RESET(32'hFFFF_FFFC), .IMEM_AW(10)) dut_w (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .resume(resume),
      .imem_addr(imem_addr_w), .imem_data(imem_data_w),
      .istr(istr_w), .if_pc(if_pc_w), .if_pc4(if_pc4_w), .if_valid(if_valid_w),
      .halted(halted_w), .pc(pc_w)
`ifdef IFETCH_PERF_EN
      , .fetch_count(fetch_count_w), .bubble_count(bubble_count_w)
`endif
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst            = v.rst;
      stall          = v.stall;
      flush          = v.flush;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      halt_req       = v.hreq;
      resume         = v.res;
   endtask

   task automatic step_and_check(input int idx, input vec_t v);
      logic [31:0]  e_istr;
      logic [129:0] e;
      drive(v);
      e_istr = (v.e_sel < 0) ? 32'h0 : rom[v.e_sel[9:0]];
      exp_q.push_back({v.e_pc, e_istr, v.e_ifpc, v.e_ifpc4, v.e_v, v.e_h});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check32($sformatf("v%0d pc", idx),       pc,                e[129:98]);
      check32($sformatf("v%0d istr", idx),     istr,              e[97:66]);
      check32($sformatf("v%0d if_pc", idx),    if_pc,             e[65:34]);
      check32($sformatf("v%0d if_pc4", idx),   if_pc4,            e[33:2]);
      check32($sformatf("v%0d if_valid", idx), {31'h0, if_valid}, {31'h0, e[1]});
      check32($sformatf("v%0d halted", idx),   {31'h0, halted},   {31'h0, e[0]});
      check32($sformatf("v%0d imem_addr", idx), {22'h0, imem_addr}, {22'h0, e[109:100]});
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = $urandom | 32'h1;
      drive('0);

      //            rst stl fl rv rpc          hq rs  e_pc          sel  ifpc          ifpc4         v  h
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h00, -32'sd1, 32'h00, 32'h00, 1'b0,1'b0};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h04,  32'sd0, 32'h00, 32'h04, 1'b1,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h08,  32'sd1, 32'h04, 32'h08, 1'b1,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h0C,  32'sd2, 32'h08, 32'h0C, 1'b1,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h10,  32'sd3, 32'h0C, 32'h10, 1'b1,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,32'h23,  1'b0,1'b0, 32'h20, -32'sd1, 32'h0C, 32'h10, 1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h24,  32'sd8, 32'h20, 32'h24, 1'b1,1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h24,  32'sd8, 32'h20, 32'h24, 1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h24,  32'sd8, 32'h20, 32'h24, 1'b1,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h24,  32'sd8, 32'h20, 32'h24, 1'b1,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0, 32'h28, -32'sd1, 32'h20, 32'h24, 1'b0,1'b0};
      vecs[11] = '{1'b0,1'b1,1'b1,1'b0,32'h0,   1'b0,1'b0, 32'h28, -32'sd1, 32'h20, 32'h24, 1'b0,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h2C, 32'sd10, 32'h28, 32'h2C, 1'b1,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b1,32'h8,   1'b0,1'b0, 32'h08, -32'sd1, 32'h28, 32'h2C, 1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1, 32'h08, -32'sd1, 32'h28, 32'h2C, 1'b0,1'b1};
      vecs[15] = '{1'b0,1'b1,1'b1,1'b1,32'h100, 1'b0,1'b0, 32'h08, -32'sd1, 32'h28, 32'h2C, 1'b0,1'b1};
      vecs[16] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0, 32'h08, -32'sd1, 32'h28, 32'h2C, 1'b0,1'b1};
      vecs[17] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1, 32'h08, -32'sd1, 32'h28, 32'h2C, 1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h0C,  32'sd2, 32'h08, 32'h0C, 1'b1,1'b0};
      vecs[19] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0, 32'h0C, -32'sd1, 32'h08, 32'h0C, 1'b0,1'b1};
      vecs[20] = '{1'b1,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h00, -32'sd1, 32'h00, 32'h00, 1'b0,1'b0};
      vecs[21] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h04,  32'sd0, 32'h00, 32'h04, 1'b1,1'b0};
      vecs[22] = '{1'b0,1'b0,1'b0,1'b1,32'h40,  1'b1,1'b0, 32'h40, -32'sd1, 32'h00, 32'h04, 1'b0,1'b0};
      vecs[23] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0, 32'h44, 32'sd16, 32'h40, 32'h44, 1'b1,1'b0};

      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         step_and_check(i, vecs[i]);
         if (i == 0 || i == 20) begin
            check32($sformatf("wrap v%0d reset pc", i), pc_w, 32'hFFFF_FFFC);
            check32($sformatf("wrap v%0d reset halted", i), {31'h0, halted_w}, 32'h0);
         end
         if (i == 1) begin
            check32("wrap pc", pc_w, 32'h0);
            check32("wrap if_pc4", if_pc4_w, 32'h0);
            check32("wrap if_pc", if_pc_w, 32'hFFFF_FFFC);
            check32("wrap istr", istr_w, rom[1023]);
         end
      end

`ifdef IFETCH_PERF_EN
      begin
         vec_t p;
         p = '0; p.rst = 1'b1; drive(p); @(posedge clk); #1;
         check32("perf reset fetch_count", fetch_count, 32'h0);
         check32("perf reset bubble_count", {16'h0, bubble_count}, 32'h0);
         p = '0; drive(p);
         repeat (5) begin @(posedge clk); #1; end
         p.rv = 1'b1; p.rpc = 32'h80; drive(p); @(posedge clk); #1;
         p = '0; p.stall = 1'b1; drive(p);
         repeat (2) begin @(posedge clk); #1; end
         check32("perf fetch_count", fetch_count, 32'd5);
         check32("perf bubble_count", {16'h0, bubble_count}, 32'd1);
      end
`endif

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage with its IF/ID pipeline register. It sits directly upstream of the instruction field splitter and decoder.
- Holds the PC and drives a combinational instruction-ROM address.
- Captures the fetched word, its PC and PC+4 into the IF/ID register.
- Supports stall, flush, branch/jump redirect and syscall-halt/resume control from downstream stages.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset (word aligned)
IMEM_AW, 10, instruction ROM word-address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC and IF/ID contents (hazard stall)
flush  input  1  replace IF/ID contents with bubble
redirect_valid  input  1  load redirect_pc into PC this cycle
redirect_pc  input  32  branch/jump target
halt_req  input  1  syscall-halt request from decode/execute
resume  input  1  leave HALT state (front-panel "go")
imem_addr  output  IMEM_AW  ROM word address = pc[IMEM_AW+1:2]
imem_data  input  32  ROM read data, combinational from imem_addr
istr  output  32  IF/ID instruction word (feeds splitter)
if_pc  output  32  IF/ID PC of istr
if_pc4  output  32  IF/ID PC+4 of istr
if_valid  output  1  IF/ID holds a real instruction
halted  output  1  stage is in HALT state
pc  output  32  current fetch PC

Behaviour:
- Reset (rst=1 at edge):
  - pc=PC_RESET, istr=32'h0 (NOP), if_pc=0, if_pc4=0, if_valid=0, halted=0.
  - State = RUN.
  - rst overrides every other input, including mid-halt or mid-stall.
- imem_addr = pc[IMEM_AW+1:2]. PC bits above IMEM_AW+1 are ignored for addressing (ROM aliases).
- Latency: an instruction at pc appears on istr one cycle after that edge. A taken redirect costs exactly one bubble.
- States:
  - RUN: normal fetch.
  - HALT: PC frozen; IF/ID forced to bubble every cycle.
- Priority per edge in RUN, highest first:
  1. rst.
  2. redirect_valid: pc<=redirect_pc & ~32'h3; IF/ID <= bubble (istr=0, if_valid=0). Wins over stall and flush in the same cycle.
  3. halt_req: state<=HALT, halted<=1, PC held, IF/ID <= bubble.
  4. flush without stall: pc<=pc+4; IF/ID <= bubble.
  5. stall: pc and all IF/ID outputs held unchanged. stall together with flush also holds; flush is not applied.
  6. Otherwise: istr<=imem_data, if_pc<=pc, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
- Bubble = istr 32'h0000_0000, if_valid 0. if_pc and if_pc4 are held at their previous values.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- HALT state:
  - redirect_valid, flush, stall and halt_req are ignored.
  - resume=1 at an edge: state<=RUN, halted<=0. Fetch restarts from the held pc on the next edge.
  - resume and halt_req in the same RUN cycle: halt_req wins; resume is ignored outside HALT.
- All outputs are registered except imem_addr, which is a direct slice of pc.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments by 1 on every edge that loads a valid instruction into IF/ID (case 6 above).
  - Wraps modulo 2^32.
  - Adds output bubble_count [15:0], reset to 0. Increments on every edge that loads a bubble while in RUN; saturates at 16'hFFFF.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Sequential fetch: reset with PC_RESET=0; ROM[0..3]=A,B,C,D; run 4 cycles -> istr=A,B,C,D on successive cycles; if_pc=0,4,8,C; if_valid=1; pc=0x10.
- Redirect: redirect_valid=1, redirect_pc=0x23 while stall=1 -> next cycle pc=0x20, istr=0, if_valid=0. The following cycle istr=ROM[8], if_pc=0x20.
- Stall and flush: stall=1 for 3 cycles -> pc and istr unchanged. Then flush=1 alone -> istr=0, if_valid=0, pc advanced by 4.
- Halt: halt_req=1 at pc=0x8 -> halted=1, pc stays 0x8, if_valid=0; redirect pulses are ignored. resume=1 -> halted=0, next edge istr=ROM[2].
- Wrap and reset: PC_RESET=32'hFFFF_FFFC -> after one fetch pc=0, if_pc4=0. Asserting rst during HALT with stall=1 -> pc=PC_RESET, halted=0, if_valid=0.
- IFETCH_PERF_EN: 5 fetches, 1 redirect, 2 stalls -> fetch_count=5, bubble_count=1.
